// File: rtl/branch_resolver_if.sv
// Bundle between the fetch/decode/execute pipeline and the branch resolver.
//   master : pipeline side, drives predictions and resolutions, reads feedback
//   slave  : resolver side
// Signals: predict_* (push a prediction), resolve_* (pop the oldest), past_* feedback,
// flush/redirect_pc, saturating statistics, queue status and sticky error flags.
interface branch_resolver_if #(
    parameter int unsigned CntW = 16
);
    logic            predict_valid;
    logic [31:0]     predict_pc;
    logic            predict_taken;
    logic [31:0]     predict_target;
    logic            resolve_valid;
    logic            resolve_taken;
    logic [31:0]     past_pc;
    logic            past_wrong;
    logic            past_predicted_taken;
    logic            past_is_branch;
    logic            flush;
    logic [31:0]     redirect_pc;
    logic [CntW-1:0] branch_count;
    logic [CntW-1:0] mispredict_count;
    logic            q_full;
    logic            q_empty;
    logic            overflow_err;
    logic            underflow_err;

    modport master (
        output predict_valid, predict_pc, predict_taken, predict_target,
        output resolve_valid, resolve_taken,
        input  past_pc, past_wrong, past_predicted_taken, past_is_branch,
        input  flush, redirect_pc, branch_count, mispredict_count,
        input  q_full, q_empty, overflow_err, underflow_err
    );

    modport slave (
        input  predict_valid, predict_pc, predict_taken, predict_target,
        input  resolve_valid, resolve_taken,
        output past_pc, past_wrong, past_predicted_taken, past_is_branch,
        output flush, redirect_pc, branch_count, mispredict_count,
        output q_full, q_empty, overflow_err, underflow_err
    );
endinterface

// File: rtl/branch_resolver.sv
// Execute-side branch resolver. Keeps decode predictions in an in-order circular queue,
// compares the oldest with the execute outcome and returns registered feedback.
// A misprediction raises a one-cycle flush with the corrected PC and squashes the queue.
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset
//   bus     branch_resolver_if.slave (predict/resolve in, feedback/status out)
module branch_resolver #(
    parameter int unsigned Depth = 4,
    parameter int unsigned CntW  = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    branch_resolver_if.slave   bus
);
    localparam int unsigned    Aw       = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned    Cw       = Aw + 1;
    localparam logic [Cw-1:0]  DepthCnt = Cw'(Depth);
    localparam logic [CntW-1:0] CntMax  = '1;

    logic [31:0]     pc_mem_q  [Depth];
    logic            tkn_mem_q [Depth];
    logic [31:0]     tgt_mem_q [Depth];

    logic [Aw-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [Cw-1:0]   cnt_q, cnt_d;
    logic [31:0]     past_pc_q, past_pc_d, redir_q, redir_d;
    logic            past_wrong_q, past_wrong_d, past_tkn_q, past_tkn_d;
    logic            pib_q, pib_d, flush_q, flush_d;
    logic [CntW-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;
    logic            full_q, full_d, empty_q, empty_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;

    logic            pop, wrong, push_ok;
    logic [31:0]     head_pc, head_tgt;
    logic            head_tkn;

    always_comb begin
        head_pc  = pc_mem_q[rd_q];
        head_tkn = tkn_mem_q[rd_q];
        head_tgt = tgt_mem_q[rd_q];
        pop      = bus.resolve_valid && (cnt_q != '0);
        wrong    = pop && (head_tkn ^ bus.resolve_taken);
        // A pop frees a slot in the same cycle, so push+pop is accepted even when full.
        push_ok  = bus.predict_valid && !wrong && (pop || (cnt_q != DepthCnt));

        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (wrong) begin
            // Everything still queued is younger than the mispredicted branch.
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (pop)     rd_d = rd_q + Aw'(1);
            if (push_ok) wr_d = wr_q + Aw'(1);
            if (push_ok && !pop)      cnt_d = cnt_q + Cw'(1);
            else if (pop && !push_ok) cnt_d = cnt_q - Cw'(1);
        end

        pib_d        = pop;
        past_pc_d    = pop ? head_pc : past_pc_q;
        past_tkn_d   = pop ? head_tkn : past_tkn_q;
        past_wrong_d = pop ? wrong : past_wrong_q;
        flush_d      = wrong;
        redir_d      = redir_q;
        if (wrong) redir_d = bus.resolve_taken ? head_tgt : head_pc + 32'd1;

        bcnt_d = (pop && (bcnt_q != CntMax)) ? bcnt_q + CntW'(1) : bcnt_q;
        mcnt_d = (wrong && (mcnt_q != CntMax)) ? mcnt_q + CntW'(1) : mcnt_q;

        full_d  = (cnt_d == DepthCnt);
        empty_d = (cnt_d == '0);
        ovf_d   = ovf_q | (bus.predict_valid && !wrong && !pop && (cnt_q == DepthCnt));
        unf_d   = unf_q | (bus.resolve_valid && (cnt_q == '0));
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            pc_mem_q[wr_q]  <= bus.predict_pc;
            tkn_mem_q[wr_q] <= bus.predict_taken;
            tgt_mem_q[wr_q] <= bus.predict_target;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q         <= '0;
            wr_q         <= '0;
            cnt_q        <= '0;
            past_pc_q    <= '0;
            past_wrong_q <= 1'b0;
            past_tkn_q   <= 1'b0;
            pib_q        <= 1'b0;
            flush_q      <= 1'b0;
            redir_q      <= '0;
            bcnt_q       <= '0;
            mcnt_q       <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            past_pc_q    <= past_pc_d;
            past_wrong_q <= past_wrong_d;
            past_tkn_q   <= past_tkn_d;
            pib_q        <= pib_d;
            flush_q      <= flush_d;
            redir_q      <= redir_d;
            bcnt_q       <= bcnt_d;
            mcnt_q       <= mcnt_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    assign bus.past_pc              = past_pc_q;
    assign bus.past_wrong           = past_wrong_q;
    assign bus.past_predicted_taken = past_tkn_q;
    assign bus.past_is_branch       = pib_q;
    assign bus.flush                = flush_q;
    assign bus.redirect_pc          = redir_q;
    assign bus.branch_count         = bcnt_q;
    assign bus.mispredict_count     = mcnt_q;
    assign bus.q_full               = full_q;
    assign bus.q_empty              = empty_q;
    assign bus.overflow_err         = ovf_q;
    assign bus.underflow_err        = unf_q;
endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    branch_resolver_if #(.CntW(CNT_W)) bus ();

    branch_resolver #(.Depth(DEPTH), .CntW(CNT_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] e_past_pc, e_redir;
    logic        e_past_wrong, e_past_taken, e_pib, e_flush, e_ovf, e_unf;
    int          e_bcnt, e_mcnt;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic model_reset();
        mq.delete();
        e_past_pc = '0; e_redir = '0; e_past_wrong = 0; e_past_taken = 0;
        e_pib = 0; e_flush = 0; e_ovf = 0; e_unf = 0; e_bcnt = 0; e_mcnt = 0;
    endtask

    task automatic drive(input logic pv, input logic [31:0] pc, input logic pt,
                         input logic [31:0] tg, input logic rv, input logic rt);
        bus.predict_valid = pv; bus.predict_pc = pc; bus.predict_taken = pt;
        bus.predict_target = tg; bus.resolve_valid = rv; bus.resolve_taken = rt;
    endtask

    // Advance the reference model by one clock using the current inputs, then step the DUT.
    task automatic cycle();
        ent_t h;
        bit   pop, wrong;
        pop = bus.resolve_valid && (mq.size() > 0);
        wrong = 0;
        e_pib = pop;
        e_flush = 0;
        if (bus.resolve_valid && mq.size() == 0) e_unf = 1;
        if (pop) begin
            h = mq.pop_front();
            wrong = (h.taken != bus.resolve_taken);
            e_past_pc = h.pc; e_past_taken = h.taken; e_past_wrong = wrong;
            e_bcnt = (e_bcnt + 1 > CNT_MAX) ? CNT_MAX : e_bcnt + 1;
            if (wrong) begin
                e_mcnt = (e_mcnt + 1 > CNT_MAX) ? CNT_MAX : e_mcnt + 1;
                e_flush = 1;
                e_redir = bus.resolve_taken ? h.target : h.pc + 32'd1;
                mq.delete();
            end
        end
        if (bus.predict_valid && !wrong) begin
            if (mq.size() < DEPTH)
                mq.push_back('{pc: bus.predict_pc, taken: bus.predict_taken,
                               target: bus.predict_target});
            else
                e_ovf = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), $urandom, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            @(posedge clk); #1;
            vectors++;
            if ({bus.past_pc, bus.past_wrong, bus.past_predicted_taken, bus.past_is_branch,
                 bus.flush, bus.redirect_pc, bus.branch_count, bus.mispredict_count,
                 bus.q_full, bus.overflow_err, bus.underflow_err} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs cycle %0d: past_pc=%h flush=%b redir=%h bcnt=%0d",
                         i, bus.past_pc, bus.flush, bus.redirect_pc, bus.branch_count);
            end
            vectors++;
            if (bus.q_empty !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_q_empty: got %b want 1", bus.q_empty);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        rst_ni = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            vectors++;
            if (bus.past_is_branch !== 1'b0 || bus.flush !== 1'b0 || bus.q_empty !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_idle: pib=%b flush=%b empty=%b want 0 0 1",
                         bus.past_is_branch, bus.flush, bus.q_empty);
            end
        end
    endtask

    task automatic test_correct();
        do_reset();
        drive(1, 32'h10, 1, 32'h20, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0);           cycle();
        drive(0, 0, 0, 0, 1, 1);           cycle();
        vectors++;
        if (bus.past_is_branch !== 1 || bus.past_pc !== 32'h10 || bus.past_wrong !== 0 ||
            bus.flush !== 0 || bus.branch_count !== 4'd1 || bus.past_predicted_taken !== 1) begin
            miscompares++;
            $display("FAIL correct_pred: pib=%b pc=%h wrong=%b flush=%b bcnt=%0d want 1 10 0 0 1",
                     bus.past_is_branch, bus.past_pc, bus.past_wrong, bus.flush,
                     bus.branch_count);
        end
        drive(0, 0, 0, 0, 0, 0); cycle();
        vectors++;
        if (bus.past_is_branch !== 0 || bus.past_pc !== 32'h10) begin
            miscompares++;
            $display("FAIL correct_hold: pib=%b pc=%h want 0 10", bus.past_is_branch,
                     bus.past_pc);
        end
    endtask

    task automatic test_mispredict_not_taken();
        do_reset();
        drive(1, 32'h40, 1, 32'h80, 0, 0); cycle();
        drive(1, 32'h50, 0, 32'h60, 0, 0); cycle();
        drive(1, 32'h51, 1, 32'h70, 0, 0); cycle();
        drive(0, 0, 0, 0, 1, 0);           cycle();
        vectors++;
        if (bus.flush !== 1 || bus.redirect_pc !== 32'h41 || bus.past_wrong !== 1 ||
            bus.q_empty !== 1 || bus.mispredict_count !== 4'd1) begin
            miscompares++;
            $display("FAIL mispred_nt: flush=%b redir=%h wrong=%b empty=%b mcnt=%0d want 1 41 1 1 1",
                     bus.flush, bus.redirect_pc, bus.past_wrong, bus.q_empty,
                     bus.mispredict_count);
        end
        drive(0, 0, 0, 0, 0, 0); cycle();
        vectors++;
        if (bus.flush !== 0 || bus.redirect_pc !== 32'h41 || bus.q_empty !== 1) begin
            miscompares++;
            $display("FAIL mispred_nt_after: flush=%b redir=%h empty=%b want 0 41 1",
                     bus.flush, bus.redirect_pc, bus.q_empty);
        end
    endtask

    task automatic test_mispredict_taken_push();
        do_reset();
        drive(1, 32'h5, 0, 32'h9, 0, 0); cycle();
        drive(1, 32'h6, 1, 32'h7, 1, 1); cycle();
        vectors++;
        if (bus.flush !== 1 || bus.redirect_pc !== 32'h9 || bus.q_empty !== 1 ||
            bus.past_pc !== 32'h5) begin
            miscompares++;
            $display("FAIL mispred_t_push: flush=%b redir=%h empty=%b pc=%h want 1 9 1 5",
                     bus.flush, bus.redirect_pc, bus.q_empty, bus.past_pc);
        end
        // The pc=0x6 entry must be gone: a resolve now hits an empty queue.
        drive(0, 0, 0, 0, 1, 1); cycle();
        vectors++;
        if (bus.past_is_branch !== 0 || bus.underflow_err !== 1) begin
            miscompares++;
            $display("FAIL mispred_t_discard: pib=%b unf=%b want 0 1", bus.past_is_branch,
                     bus.underflow_err);
        end
    endtask

    task automatic test_full_wrap();
        logic [31:0] want [4];
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h100 + 32'(i), 0, 32'h0, 0, 0); cycle();
        end
        vectors++;
        if (bus.q_full !== 1 || bus.overflow_err !== 0) begin
            miscompares++;
            $display("FAIL full_set: full=%b ovf=%b want 1 0", bus.q_full, bus.overflow_err);
        end
        drive(1, 32'h1ff, 0, 0, 0, 0); cycle();
        vectors++;
        if (bus.overflow_err !== 1 || bus.q_full !== 1) begin
            miscompares++;
            $display("FAIL overflow: ovf=%b full=%b want 1 1", bus.overflow_err, bus.q_full);
        end
        drive(1, 32'h104, 0, 0, 1, 0); cycle();
        vectors++;
        if (bus.q_full !== 1 || bus.past_pc !== 32'h100 || bus.flush !== 0) begin
            miscompares++;
            $display("FAIL full_pushpop: full=%b pc=%h flush=%b want 1 100 0",
                     bus.q_full, bus.past_pc, bus.flush);
        end
        want = '{32'h101, 32'h102, 32'h103, 32'h104};
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 0, 1, 0); cycle();
            vectors++;
            if (bus.past_is_branch !== 1 || bus.past_pc !== want[i] || bus.q_full !== 0) begin
                miscompares++;
                $display("FAIL drain_order %0d: pib=%b pc=%h want 1 %h",
                         i, bus.past_is_branch, bus.past_pc, want[i]);
            end
        end
        vectors++;
        if (bus.q_empty !== 1) begin
            miscompares++;
            $display("FAIL drain_empty: got %b want 1", bus.q_empty);
        end
    endtask

    task automatic test_underflow_sat();
        do_reset();
        drive(0, 0, 0, 0, 1, 0); cycle();
        vectors++;
        if (bus.underflow_err !== 1 || bus.past_is_branch !== 0 || bus.flush !== 0) begin
            miscompares++;
            $display("FAIL underflow: unf=%b pib=%b flush=%b want 1 0 0",
                     bus.underflow_err, bus.past_is_branch, bus.flush);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1, 32'h300 + 32'(i), 0, 32'h400, 0, 0); cycle();
            drive(0, 0, 0, 0, 1, 1);                      cycle();
        end
        vectors++;
        if (bus.branch_count !== 4'd15 || bus.mispredict_count !== 4'd15) begin
            miscompares++;
            $display("FAIL saturation: bcnt=%0d mcnt=%0d want 15 15",
                     bus.branch_count, bus.mispredict_count);
        end
    endtask

    task automatic test_random();
        logic pt;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            pt = 1'($urandom);
            // Mostly-correct outcomes so the queue gets a chance to fill.
            drive($urandom_range(0, 99) < 55, $urandom, pt, $urandom,
                  $urandom_range(0, 99) < 40,
                  ($urandom_range(0, 99) < 85) ? pt : ~pt);
            cycle();
            vectors++;
            if (bus.past_is_branch !== e_pib || bus.past_pc !== e_past_pc ||
                bus.past_wrong !== e_past_wrong || bus.past_predicted_taken !== e_past_taken ||
                bus.flush !== e_flush || bus.redirect_pc !== e_redir) begin
                miscompares++;
                $display("FAIL rand_feedback %0d: pib=%b pc=%h w=%b t=%b fl=%b rd=%h want %b %h %b %b %b %h",
                         i, bus.past_is_branch, bus.past_pc, bus.past_wrong,
                         bus.past_predicted_taken, bus.flush, bus.redirect_pc, e_pib,
                         e_past_pc, e_past_wrong, e_past_taken, e_flush, e_redir);
            end
            vectors++;
            if (bus.branch_count !== CNT_W'(e_bcnt) || bus.mispredict_count !== CNT_W'(e_mcnt) ||
                bus.q_full !== (mq.size() == DEPTH) || bus.q_empty !== (mq.size() == 0) ||
                bus.overflow_err !== e_ovf || bus.underflow_err !== e_unf) begin
                miscompares++;
                $display("FAIL rand_status %0d: b=%0d m=%0d f=%b e=%b o=%b u=%b want %0d %0d size=%0d %b %b",
                         i, bus.branch_count, bus.mispredict_count, bus.q_full, bus.q_empty,
                         bus.overflow_err, bus.underflow_err, e_bcnt, e_mcnt, mq.size(),
                         e_ovf, e_unf);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        drive(1, 32'h200, 1, 32'h280, 0, 0); cycle();
        drive(0, 0, 0, 0, 1, 0);             cycle();
        vectors++;
        if (bus.flush !== 1 || bus.past_is_branch !== 1) begin
            miscompares++;
            $display("FAIL pre_reset_flush: flush=%b pib=%b want 1 1", bus.flush,
                     bus.past_is_branch);
        end
        drive(0, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        #1;
        vectors++;
        if (bus.flush !== 0 || bus.past_is_branch !== 0 || bus.redirect_pc !== 0 ||
            bus.past_pc !== 0 || bus.q_empty !== 1 || bus.branch_count !== 0) begin
            miscompares++;
            $display("FAIL async_reset: flush=%b pib=%b redir=%h pc=%h empty=%b want 0 0 0 0 1",
                     bus.flush, bus.past_is_branch, bus.redirect_pc, bus.past_pc, bus.q_empty);
        end
        model_reset();
        @(posedge clk); #1;
        rst_ni = 1'b1;
        cycle();
        vectors++;
        if (bus.flush !== 0 || bus.past_is_branch !== 0) begin
            miscompares++;
            $display("FAIL post_reset_idle: flush=%b pib=%b want 0 0", bus.flush,
                     bus.past_is_branch);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_correct();
        test_mispredict_not_taken();
        test_mispredict_taken_push();
        test_full_wrap();
        test_underflow_sat();
        test_random();
        test_reset_mid_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
